// File: rtl/stim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stim_pkg
// Description : Shared types and default timing for the biphasic stimulation
//               output stage. Holds the FSM state enum, default pulse
//               timing constants and the width of the pulse index.
// Revision    : 1.0 - initial release
// ============================================================================
package stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POS     = 3'd1,
        ST_GAP     = 3'd2,
        ST_NEG     = 3'd3,
        ST_REST    = 3'd4,
        ST_REFRACT = 3'd5
    } stim_state_t;

    localparam int unsigned DEF_PHASE_CYC   = 4;
    localparam int unsigned DEF_GAP_CYC     = 2;
    localparam int unsigned DEF_PERIOD_CYC  = 20;
    localparam int unsigned DEF_NUM_PULSES  = 3;
    localparam int unsigned DEF_REFRACT_CYC = 50;
    localparam int          DEF_CNT_WIDTH   = 16;

    localparam int          PULSE_IDX_W     = 8;

endpackage
`default_nettype wire

// File: rtl/stim_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : stim_phase_timer
// Description : Down-counter used to time every FSM state. Loaded with
//               (duration-1) on state entry; holds at zero once expired.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-low reset
//               load      - load load_val this cycle (priority over count)
//               load_val  - value to load
//               zero      - counter currently equals zero
// Revision    : 1.0 - initial release
// ============================================================================
module stim_phase_timer #(
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [cnt_width-1:0] load_val,
    output logic                 zero
);

    localparam logic [cnt_width-1:0] c_ONE = cnt_width'(1);

    logic [cnt_width-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/stim_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : stim_pulse_gen
// Description : Converts the rising edge of the classifier 'stimulation'
//               level into a charge-balanced biphasic pulse train
//               (POS / GAP / NEG, REST between pulses) followed by a
//               refractory lockout. All outputs are registered decodes of
//               the current state, so they appear one cycle after the state.
// Build macro : STIM_SAFE_ABORT_EN - when defined, an abort (en=1) during
//               POS/GAP/NEG lets the current pulse finish its NEG phase
//               before returning to IDLE; otherwise abort goes straight to
//               IDLE from any state.
// Ports       : clk          - sole clock, rising edge
//               rst          - asynchronous active-low reset
//               en           - active-low enable; 1 blocks triggers / aborts
//               stimulation  - detection level from controller
//               phase_pos    - anodic switch drive
//               phase_neg    - cathodic switch drive
//               busy         - FSM not idle
//               pulse_idx    - 0-based index of current pulse
//               train_done   - one-cycle strobe on entering refractory
// Revision    : 1.0 - initial release
// ============================================================================
module stim_pulse_gen
    import stim_pkg::*;
#(
    parameter int unsigned PHASE_CYC   = DEF_PHASE_CYC,
    parameter int unsigned GAP_CYC     = DEF_GAP_CYC,
    parameter int unsigned PERIOD_CYC  = DEF_PERIOD_CYC,
    parameter int unsigned NUM_PULSES  = DEF_NUM_PULSES,
    parameter int unsigned REFRACT_CYC = DEF_REFRACT_CYC,
    parameter int          cnt_width   = DEF_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   stimulation,
    output logic                   phase_pos,
    output logic                   phase_neg,
    output logic                   busy,
    output logic [PULSE_IDX_W-1:0] pulse_idx,
    output logic                   train_done
);

    localparam int unsigned REST_CYC = PERIOD_CYC - 2 * PHASE_CYC - GAP_CYC;

    localparam logic [cnt_width-1:0]   c_PHASE_LOAD   = cnt_width'(PHASE_CYC - 1);
    localparam logic [cnt_width-1:0]   c_GAP_LOAD     = cnt_width'(GAP_CYC - 1);
    localparam logic [cnt_width-1:0]   c_REST_LOAD    = cnt_width'(REST_CYC - 1);
    localparam logic [cnt_width-1:0]   c_REFRACT_LOAD = cnt_width'(REFRACT_CYC - 1);
    localparam logic [PULSE_IDX_W-1:0] c_LAST_IDX     = PULSE_IDX_W'(NUM_PULSES - 1);
    localparam logic [PULSE_IDX_W-1:0] c_IDX_ONE      = PULSE_IDX_W'(1);

    stim_state_t            r_state;
    stim_state_t            w_next;
    logic                   r_stim_prev;
    logic                   r_first;
    logic [PULSE_IDX_W-1:0] r_idx;
    logic                   w_trigger;
    logic                   w_zero;
    logic                   w_load;
    logic [cnt_width-1:0]   w_load_val;

    logic                   w_pos_d;
    logic                   w_neg_d;
    logic                   w_busy_d;
    logic                   w_done_d;

    // Only a fresh 0->1 edge while enabled can start a train; the IDLE
    // qualification is applied in the next-state logic.
    assign w_trigger = stimulation & ~r_stim_prev & ~en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stim_prev <= 1'b0;
        end else begin
            r_stim_prev <= stimulation;
        end
    end

`ifdef STIM_SAFE_ABORT_EN
    // An en pulse seen mid-pulse must be remembered until NEG completes.
    logic r_abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_abort <= 1'b0;
        end else if (w_next == ST_IDLE) begin
            r_abort <= 1'b0;
        end else if (en) begin
            r_abort <= 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= w_load;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_trigger) w_next = ST_POS;
            ST_POS:     if (w_zero)    w_next = ST_GAP;
            ST_GAP:     if (w_zero)    w_next = ST_NEG;
            ST_NEG: begin
                if (w_zero) begin
                    if (r_idx < c_LAST_IDX) w_next = ST_REST;
                    else                    w_next = ST_REFRACT;
                end
            end
            ST_REST:    if (w_zero)    w_next = ST_POS;
            ST_REFRACT: if (w_zero)    w_next = ST_IDLE;
            default:                   w_next = ST_IDLE;
        endcase

`ifdef STIM_SAFE_ABORT_EN
        // POS and GAP run to completion; the pulse always ends with a full
        // NEG phase, after which an abort returns to IDLE.
        if (r_state == ST_NEG && w_zero && (en || r_abort)) begin
            w_next = ST_IDLE;
        end
        if ((r_state == ST_REST || r_state == ST_REFRACT) && en) begin
            w_next = ST_IDLE;
        end
`else
        if (r_state != ST_IDLE && en) begin
            w_next = ST_IDLE;
        end
`endif
    end

    // Timer reloads on every state change, including REST->POS.
    assign w_load = (w_next != r_state);

    always_comb begin
        w_load_val = '0;
        case (w_next)
            ST_POS:     w_load_val = c_PHASE_LOAD;
            ST_GAP:     w_load_val = c_GAP_LOAD;
            ST_NEG:     w_load_val = c_PHASE_LOAD;
            ST_REST:    w_load_val = c_REST_LOAD;
            ST_REFRACT: w_load_val = c_REFRACT_LOAD;
            default:    w_load_val = '0;
        endcase
    end

    stim_phase_timer #(
        .cnt_width (cnt_width)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_zero)
    );

    // Pulse index advances as the next pulse starts and clears on IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (w_next == ST_IDLE) begin
            r_idx <= '0;
        end else if (r_state == ST_REST && w_next == ST_POS) begin
            r_idx <= r_idx + c_IDX_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Output decode and output registers
    // ------------------------------------------------------------------
    always_comb begin
        w_pos_d  = (r_state == ST_POS);
        w_neg_d  = (r_state == ST_NEG);
        w_busy_d = (r_state != ST_IDLE);
        // REFRACT is entered only from a non-aborted NEG, so its first
        // cycle marks the end of a completed train.
        w_done_d = (r_state == ST_REFRACT) && r_first;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_pos  <= 1'b0;
            phase_neg  <= 1'b0;
            busy       <= 1'b0;
            train_done <= 1'b0;
            pulse_idx  <= '0;
        end else begin
            phase_pos  <= w_pos_d;
            phase_neg  <= w_neg_d;
            busy       <= w_busy_d;
            train_done <= w_done_d;
            pulse_idx  <= r_idx;
        end
    end

endmodule
`default_nettype wire
